fifo_ctrl: RTL

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/syn_fifo_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/fifo_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the synchronous FIFO controller: read-side FSM states
// and default entry width and depth.
package syn_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 25;
  localparam int unsigned DEFAULT_DEPTH      = 256;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. On contention it favours the requester not granted
// last. After reset the history favours requester 0.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Set when requester 1 won most recently, which hands priority to requester 0.
  logic last_was_1;

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_was_1 ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_was_1 <= 1'b1;
    end else if (advance) begin
      last_was_1 <= gnt[1];
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Controller for an external circular buffer with two round-robin producers and
// one registered consumer slot. Optional FIFO_CTRL_CLEAR_EN adds a synchronous clear.
module fifo_ctrl
  import syn_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL   = DEPTH - 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef FIFO_CTRL_CLEAR_EN
  input  logic                    clear,
  output logic                    fifo_clear,
`endif
  input  logic                    req0_valid,
  input  logic [DATA_WIDTH-1:0]   req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [DATA_WIDTH-1:0]   req1_data,
  output logic                    req1_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    fifo_wren,
  output logic [DATA_WIDTH-1:0]   fifo_di,
  output logic                    fifo_rden,
  input  logic [DATA_WIDTH-1:0]   fifo_do,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  out_state_e state, state_nxt;
  logic       clr;
  logic       grant_en;
  logic [1:0] gnt;

`ifdef FIFO_CTRL_CLEAR_EN
  assign clr        = clear;
  assign fifo_clear = clear;
`else
  assign clr = 1'b0;
`endif

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_LEVEL));

  // rst_n gates the grant so no write strobe escapes while reset is held.
  assign grant_en = rst_n && !full && !clr;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid, req0_valid} & {2{grant_en}}),
    .advance (fifo_wren),
    .gnt     (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign fifo_wren  = |gnt;
  assign fifo_di    = gnt[1] ? req1_data : req0_data;

  assign fifo_rden = !clr && !empty && ((state == OUT_EMPTY) || out_ready);
  assign out_valid = (state == OUT_VALID);
  assign out_data  = fifo_do;

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = OUT_EMPTY;
    end else if (fifo_rden) begin
      state_nxt = OUT_VALID;
    end else if ((state == OUT_VALID) && out_ready) begin
      state_nxt = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (fifo_wren && !fifo_rden) begin
      count <= count + CW'(1);
    end else if (fifo_rden && !fifo_wren) begin
      count <= count - CW'(1);
    end
  end

endmodule
